// File: rtl/dice_turn_sequencer.sv
// dice_turn_sequencer: grants the shared dice roller to the player owning the turn,
// captures and shows each roll, and alternates turns until game over, draw or fault
module dice_turn_sequencer #(
   parameter int MAX_ROUNDS   = 15,
   parameter int ROLL_TIMEOUT = 255,
   parameter int SHOW_CYCLES  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       req1,
   input  logic       req2,
   input  logic       roll_done,
   input  logic [4:0] sum,
   input  logic       game_over,
   output logic [3:0] turn,
   output logic       roll_go,
   output logic [4:0] last_sum,
   output logic [3:0] round_cnt,
   output logic       busy,
   output logic       foul,
   output logic       draw,
   output logic       fault
);
   typedef enum logic [3:0] {IDLE, WAIT1, ROLL1, SHOW1, WAIT2, ROLL2, SHOW2, DONE, FAULT} state_t;
   state_t state, state_n;
   logic req1_q, req2_q, edge1, edge2;
   logic [7:0] tcnt, tcnt_n;
   logic [3:0] scnt, scnt_n, round_n;
   logic [4:0] last_n;
   logic draw_n, foul_n;
   assign edge1 = req1 & ~req1_q;
   assign edge2 = req2 & ~req2_q;
   always_comb begin
      state_n = state;
      tcnt_n  = tcnt + 8'd1;
      scnt_n  = scnt + 4'd1;
      last_n  = last_sum;
      round_n = round_cnt;
      draw_n  = draw;
      foul_n  = 1'b0;
      case (state)
         IDLE, DONE: if (start) begin
            state_n = WAIT1;
            round_n = 4'd0;
            draw_n  = 1'b0;
            last_n  = 5'd0;
         end
         WAIT1: begin
            foul_n = edge2;
            if (edge1) begin
               state_n = ROLL1;
               tcnt_n  = 8'd0;
            end
         end
         WAIT2: begin
            foul_n = edge1;
            if (edge2) begin
               state_n = ROLL2;
               tcnt_n  = 8'd0;
            end
         end
         ROLL1, ROLL2: if (roll_done) begin
            state_n = (state == ROLL1) ? SHOW1 : SHOW2;
            last_n  = sum;
            scnt_n  = 4'd0;
         end else if (tcnt == 8'(ROLL_TIMEOUT - 1)) state_n = FAULT;
         SHOW1: if (scnt == 4'(SHOW_CYCLES - 1)) state_n = game_over ? DONE : WAIT2;
         SHOW2: if (scnt == 4'(SHOW_CYCLES - 1)) begin
            if (game_over) state_n = DONE;
            else begin
               // game_over has priority, so a winning last round is not counted as a draw
               round_n = round_cnt + 4'd1;
               draw_n  = (round_n == 4'(MAX_ROUNDS));
               state_n = draw_n ? DONE : WAIT1;
            end
         end
         default: state_n = FAULT;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         req1_q    <= 1'b0;
         req2_q    <= 1'b0;
         tcnt      <= 8'd0;
         scnt      <= 4'd0;
         turn      <= 4'd0;
         roll_go   <= 1'b0;
         last_sum  <= 5'd0;
         round_cnt <= 4'd0;
         busy      <= 1'b0;
         foul      <= 1'b0;
         draw      <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_n;
         req1_q    <= req1;
         req2_q    <= req2;
         tcnt      <= tcnt_n;
         scnt      <= scnt_n;
         turn      <= (state_n inside {WAIT1, ROLL1, SHOW1}) ? 4'd1 :
                      (state_n inside {WAIT2, ROLL2, SHOW2}) ? 4'd2 : 4'd0;
         roll_go   <= (state_n inside {ROLL1, ROLL2}) && (state_n != state);
         last_sum  <= last_n;
         round_cnt <= round_n;
         busy      <= !(state_n inside {IDLE, DONE, FAULT});
         foul      <= foul_n;
         draw      <= draw_n;
         fault     <= (state_n == FAULT);
      end
   end
endmodule

// File: tb/tb_dice_turn_sequencer.sv
// tb_dice_turn_sequencer: vector table, corner-case sequences and random play
// checked against a phase/player reference model of the game rules
module tb_dice_turn_sequencer;
   localparam int MR = 2, TO = 8, SC = 4;
   localparam int P_IDLE = 0, P_WAIT = 1, P_ROLL = 2, P_SHOW = 3, P_DONE = 4, P_FAULT = 5;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, req1 = 1'b0, req2 = 1'b0, roll_done = 1'b0, game_over = 1'b0;
   logic [4:0] sum = 5'd0;
   logic [3:0] turn, round_cnt;
   logic [4:0] last_sum;
   logic roll_go, busy, foul, draw, fault;
   int n_chk = 0, n_fail = 0, n_cyc = 0;
   int m_phase, m_player, m_elapsed, m_last, m_rounds;
   bit m_draw, m_go, m_foul, m_p1, m_p2;
   typedef struct {
      bit rs, st, r1, r2, rd;
      int sm;
      bit go;
      int t, g, l, rc, b, f, d, ft;
   } vec_t;
   vec_t vecs[$];

   dice_turn_sequencer #(.MAX_ROUNDS(MR), .ROLL_TIMEOUT(TO), .SHOW_CYCLES(SC)) dut (
      .clk(clk), .rst(rst), .start(start), .req1(req1), .req2(req2), .roll_done(roll_done),
      .sum(sum), .game_over(game_over), .turn(turn), .roll_go(roll_go), .last_sum(last_sum),
      .round_cnt(round_cnt), .busy(busy), .foul(foul), .draw(draw), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // one clock of the game rules, in terms of phase, owning player and elapsed cycles
   task automatic model_step();
      bit e1, e2, own, oth;
      m_go = 0;
      m_foul = 0;
      if (!rst) begin
         m_phase = P_IDLE; m_player = 0; m_last = 0; m_rounds = 0; m_draw = 0; m_p1 = 0; m_p2 = 0;
         return;
      end
      e1 = req1 && !m_p1;
      e2 = req2 && !m_p2;
      m_p1 = req1;
      m_p2 = req2;
      case (m_phase)
         P_IDLE, P_DONE: if (start) begin
            m_phase = P_WAIT; m_player = 1; m_rounds = 0; m_draw = 0; m_last = 0;
         end
         P_WAIT: begin
            own = (m_player == 1) ? e1 : e2;
            oth = (m_player == 1) ? e2 : e1;
            m_foul = oth;
            if (own) begin m_phase = P_ROLL; m_go = 1; m_elapsed = 0; end
         end
         P_ROLL: begin
            m_elapsed++;
            if (roll_done) begin m_last = int'(sum); m_phase = P_SHOW; m_elapsed = 0; end
            else if (m_elapsed == TO) m_phase = P_FAULT;
         end
         P_SHOW: begin
            m_elapsed++;
            if (m_elapsed == SC) begin
               if (game_over) m_phase = P_DONE;
               else if (m_player == 1) begin m_player = 2; m_phase = P_WAIT; end
               else begin
                  m_rounds++;
                  if (m_rounds == MR) begin m_phase = P_DONE; m_draw = 1; end
                  else begin m_player = 1; m_phase = P_WAIT; end
               end
            end
         end
         default: ;
      endcase
   endtask

   task automatic cyc(input bit rs, st, r1, r2, rd, input int sm, input bit go);
      bit act;
      @(negedge clk);
      rst = rs; start = st; req1 = r1; req2 = r2; roll_done = rd; sum = 5'(sm); game_over = go;
      @(posedge clk);
      model_step();
      #1;
      n_cyc++;
      act = (m_phase == P_WAIT || m_phase == P_ROLL || m_phase == P_SHOW);
      chk($sformatf("cyc%0d.turn", n_cyc), int'(turn), act ? m_player : 0);
      chk($sformatf("cyc%0d.busy", n_cyc), int'(busy), int'(act));
      chk($sformatf("cyc%0d.roll_go", n_cyc), int'(roll_go), int'(m_go));
      chk($sformatf("cyc%0d.last_sum", n_cyc), int'(last_sum), m_last);
      chk($sformatf("cyc%0d.round_cnt", n_cyc), int'(round_cnt), m_rounds);
      chk($sformatf("cyc%0d.foul", n_cyc), int'(foul), int'(m_foul));
      chk($sformatf("cyc%0d.draw", n_cyc), int'(draw), int'(m_draw));
      chk($sformatf("cyc%0d.fault", n_cyc), int'(fault), int'(m_phase == P_FAULT));
   endtask

   task automatic add(input bit rs, st, r1, r2, rd, input int sm, input bit go,
                      input int t, g, l, rc, b, f, d, ft);
      vec_t x;
      x.rs = rs; x.st = st; x.r1 = r1; x.r2 = r2; x.rd = rd; x.sm = sm; x.go = go;
      x.t = t; x.g = g; x.l = l; x.rc = rc; x.b = b; x.f = f; x.d = d; x.ft = ft;
      vecs.push_back(x);
   endtask

   initial begin
      bit r1s, r2s, rs;
      int gos, fls;
      // rs st r1 r2 rd sum go | turn go last rnd busy foul draw fault
      add(0,0,0,0,0, 0,0, 0,0, 0,0,0,0,0,0);
      add(1,0,0,0,0, 0,0, 0,0, 0,0,0,0,0,0);
      add(1,1,0,0,0, 0,0, 1,0, 0,0,1,0,0,0);
      add(1,0,0,1,0, 0,0, 1,0, 0,0,1,1,0,0);
      add(1,0,0,0,0, 0,0, 1,0, 0,0,1,0,0,0);
      add(1,0,1,0,0, 0,0, 1,1, 0,0,1,0,0,0);
      add(1,0,1,0,0, 0,0, 1,0, 0,0,1,0,0,0);
      add(1,0,1,0,1, 7,0, 1,0, 7,0,1,0,0,0);
      add(1,0,0,0,0, 0,0, 1,0, 7,0,1,0,0,0);
      add(1,0,0,0,1, 3,0, 1,0, 7,0,1,0,0,0);
      add(1,0,0,1,0, 0,0, 1,0, 7,0,1,0,0,0);
      add(1,0,0,1,0, 0,0, 2,0, 7,0,1,0,0,0);
      add(1,0,1,0,0, 0,0, 2,0, 7,0,1,1,0,0);
      add(1,0,0,1,0, 0,0, 2,1, 7,0,1,0,0,0);
      add(1,0,0,0,0, 0,0, 2,0, 7,0,1,0,0,0);
      add(1,0,0,0,1, 9,0, 2,0, 9,0,1,0,0,0);
      for (int i = 0; i < 3; i++) add(1,0,0,0,0, 0,0, 2,0, 9,0,1,0,0,0);
      add(1,0,0,0,0, 0,0, 1,0, 9,1,1,0,0,0);
      add(1,0,1,0,0, 0,0, 1,1, 9,1,1,0,0,0);
      add(1,0,0,0,1,12,0, 1,0,12,1,1,0,0,0);
      for (int i = 0; i < 3; i++) add(1,0,0,0,0, 0,0, 1,0,12,1,1,0,0,0);
      add(1,0,0,0,0, 0,0, 2,0,12,1,1,0,0,0);
      add(1,0,0,1,0, 0,0, 2,1,12,1,1,0,0,0);
      add(1,0,0,0,1, 2,0, 2,0, 2,1,1,0,0,0);
      for (int i = 0; i < 3; i++) add(1,0,0,0,0, 0,0, 2,0, 2,1,1,0,0,0);
      add(1,0,0,0,0, 0,0, 0,0, 2,2,0,0,1,0);
      add(1,0,1,0,1, 4,0, 0,0, 2,2,0,0,1,0);
      add(1,1,0,0,0, 0,0, 1,0, 0,0,1,0,0,0);
      add(1,0,1,0,0, 0,0, 1,1, 0,0,1,0,0,0);
      add(1,0,0,0,1,11,0, 1,0,11,0,1,0,0,0);
      add(1,0,0,0,0, 0,0, 1,0,11,0,1,0,0,0);
      add(1,0,0,0,0, 0,1, 1,0,11,0,1,0,0,0);
      add(1,0,0,0,0, 0,0, 1,0,11,0,1,0,0,0);
      add(1,0,0,0,0, 0,1, 0,0,11,0,0,0,0,0);
      add(1,1,0,0,0, 0,0, 1,0, 0,0,1,0,0,0);
      add(1,0,0,0,0, 0,0, 1,0, 0,0,1,0,0,0);
      foreach (vecs[i]) begin
         cyc(vecs[i].rs, vecs[i].st, vecs[i].r1, vecs[i].r2, vecs[i].rd, vecs[i].sm, vecs[i].go);
         chk($sformatf("vec%0d.turn", i), int'(turn), vecs[i].t);
         chk($sformatf("vec%0d.roll_go", i), int'(roll_go), vecs[i].g);
         chk($sformatf("vec%0d.last_sum", i), int'(last_sum), vecs[i].l);
         chk($sformatf("vec%0d.round_cnt", i), int'(round_cnt), vecs[i].rc);
         chk($sformatf("vec%0d.busy", i), int'(busy), vecs[i].b);
         chk($sformatf("vec%0d.foul", i), int'(foul), vecs[i].f);
         chk($sformatf("vec%0d.draw", i), int'(draw), vecs[i].d);
         chk($sformatf("vec%0d.fault", i), int'(fault), vecs[i].ft);
      end

      // timeout: FAULT exactly TO cycles after ROLL1 entry, requests then ignored
      cyc(0,0,0,0,0,0,0); cyc(1,1,0,0,0,0,0); cyc(1,0,1,0,0,0,0);
      for (int i = 0; i < TO - 1; i++) cyc(1,0,0,0,0,0,0);
      chk("to_before.fault", int'(fault), 0);
      chk("to_before.turn", int'(turn), 1);
      cyc(1,0,0,0,0,0,0);
      chk("to_at.fault", int'(fault), 1);
      chk("to_at.turn", int'(turn), 0);
      chk("to_at.busy", int'(busy), 0);
      cyc(1,1,1,0,1,6,0);
      chk("to_sticky.fault", int'(fault), 1);
      // roll_done on the final allowed cycle beats the timeout
      cyc(0,0,0,0,0,0,0); cyc(1,1,0,0,0,0,0); cyc(1,0,1,0,0,0,0);
      for (int i = 0; i < TO - 1; i++) cyc(1,0,0,0,0,0,0);
      cyc(1,0,0,0,1,6,0);
      chk("to_late.fault", int'(fault), 0);
      chk("to_late.last_sum", int'(last_sum), 6);
      chk("to_late.turn", int'(turn), 1);

      // simultaneous request edges in WAIT1
      cyc(0,0,0,0,0,0,0); cyc(1,1,0,0,0,0,0); cyc(1,0,1,1,0,0,0);
      chk("both.roll_go", int'(roll_go), 1);
      chk("both.foul", int'(foul), 1);
      cyc(1,0,1,1,0,0,0);
      chk("both_after.foul", int'(foul), 0);

      // req1 held for 20 cycles gives a single roll
      cyc(0,0,0,0,0,0,0); cyc(1,1,0,0,0,0,0);
      gos = 0; fls = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1,0,1,0,(i == 3),8,0);
         gos += int'(roll_go);
         fls += int'(foul);
      end
      chk("hold.roll_go_count", gos, 1);
      chk("hold.foul_count", fls, 0);
      chk("hold.turn", int'(turn), 2);

      // reset during ROLL2 aborts the roll; stray inputs ignored until start
      cyc(0,0,0,0,0,0,0); cyc(1,1,0,0,0,0,0); cyc(1,0,1,0,0,0,0); cyc(1,0,0,0,1,10,0);
      for (int i = 0; i < SC; i++) cyc(1,0,0,0,0,0,0);
      cyc(1,0,0,1,0,0,0);
      chk("mid.turn", int'(turn), 2);
      chk("mid.roll_go", int'(roll_go), 1);
      cyc(0,0,0,0,0,0,0);
      chk("rst.outputs", {turn, roll_go, last_sum, round_cnt, busy, foul, draw, fault}, 0);
      cyc(1,0,1,0,1,5,0);
      chk("rst_ign.outputs", {turn, roll_go, last_sum, round_cnt, busy, foul, draw, fault}, 0);
      cyc(1,1,0,0,0,0,0);
      chk("rst_start.turn", int'(turn), 1);
      chk("rst_start.busy", int'(busy), 1);

      // random play against the model
      r1s = 0; r2s = 0;
      cyc(0,0,0,0,0,0,0);
      for (int i = 0; i < 3000; i++) begin
         rs = ($urandom_range(0, 299) != 0);
         if (m_phase == P_FAULT && $urandom_range(0, 9) == 0) rs = 0;
         if ($urandom_range(0, 2) == 0) r1s = ~r1s;
         if ($urandom_range(0, 2) == 0) r2s = ~r2s;
         cyc(rs, ($urandom_range(0, 3) == 0), r1s, r2s, ($urandom_range(0, 4) == 0),
             int'($urandom_range(2, 12)), ($urandom_range(0, 11) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dice_turn_sequencer.md
# dice_turn_sequencer

Turn sequencer and shared-roller controller for the two-player dice game. It accepts roll requests from both players, grants the single dice roller to whichever player owns the turn, and issues a one-cycle roll command. It captures the rolled sum, holds it for display, and hands turns back and forth until the rules block reports game over or a round limit is reached. It sits between the player push-button synchronizers and the dice datapath/rules block, and drives the `turn` code that the rules block consumes.

## Interface
- `MAX_ROUNDS`, default 15: full P1+P2 rounds before a draw is declared; range 1..15.
- `ROLL_TIMEOUT`, default 255: cycles allowed from `roll_go` to `roll_done`; range 2..255.
- `SHOW_CYCLES`, default 4: cycles the sum is held before the turn passes; range 1..15.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  level; sampled only in IDLE/DONE; begins a new game.
- `req1`, `req2`  in  1 each  player roll requests (already synchronized); rising edge is the request.
- `roll_done`  in  1  one-cycle pulse from the dice datapath; `sum` is valid in the same cycle.
- `sum`  in  5  rolled total, 2..12.
- `game_over`  in  1  from the rules block (win1|win2), level.
- `turn`  out  4  0 = no turn, 1 = player 1, 2 = player 2.
- `roll_go`  out  1  one-cycle roll command to the dice datapath.
- `last_sum`  out  5  most recently captured sum.
- `round_cnt`  out  4  completed rounds.
- `busy`  out  1  high in every state except IDLE, DONE and FAULT.
- `foul`  out  1  one-cycle pulse when an out-of-turn request edge occurs.
- `draw`  out  1  high in DONE when the round limit ended the game.
- `fault`  out  1  sticky roll-timeout flag.

## Operation
- States: IDLE, WAIT1, ROLL1, SHOW1, WAIT2, ROLL2, SHOW2, DONE, FAULT.
- Edge detect: `req1` and `req2` are each registered once. An edge is the current value 1 with the registered value 0.
- IDLE/DONE: when `start`=1, clear `round_cnt`, `draw` and `last_sum`, then go to WAIT1. Otherwise hold.
- WAITn: an edge on `reqn` moves the FSM to ROLLn. An edge on the other player's request pulses `foul` and is otherwise ignored. If both edges arrive in the same cycle, the owner's edge is accepted and `foul` pulses.
- ROLLn:
  - `roll_go`=1 in the first ROLLn cycle only.
  - The timeout counter starts at 0 on entry and increments each cycle.
  - `roll_done`=1: capture `sum` into `last_sum` and go to SHOWn.
  - Counter reaching ROLL_TIMEOUT-1 without `roll_done`: go to FAULT.
  - `roll_done` and timeout in the same cycle: `roll_done` wins.
- SHOWn: hold for SHOW_CYCLES cycles, then sample `game_over` on the last cycle.
  - `game_over`=1: go to DONE.
  - SHOW1 otherwise: go to WAIT2.
  - SHOW2 otherwise: increment `round_cnt`. If the new value equals MAX_ROUNDS, go to DONE with `draw`=1; else go to WAIT1.
- FAULT: `fault`=1, `turn`=0, all requests ignored. Exit is by reset only.
- `roll_done` outside ROLLn is ignored. `start` outside IDLE/DONE is ignored. Request edges in IDLE/SHOW/DONE/FAULT are ignored, with no `foul`.
- `turn` is 1 in WAIT1/ROLL1/SHOW1, 2 in WAIT2/ROLL2/SHOW2, and 0 elsewhere.
- `round_cnt` is 4-bit and never wraps, because the limit stops it.

## Timing
- Reset (`rst`=0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0: `turn`, `roll_go`, `last_sum`, `round_cnt`, `busy`, `foul`, `draw`, `fault`.
  - The edge-detect registers load 0.
  - Reset mid-roll aborts the roll. A `roll_done` arriving after reset is ignored.
- All outputs are registered.
- A request edge sampled at edge N produces ROLLn and `roll_go`=1 in cycle N+1. This is one cycle of latency.
- `roll_done` sampled at edge M produces SHOWn and updated `last_sum` from cycle M+1.
- SHOWn lasts exactly SHOW_CYCLES cycles. The next state is visible SHOW_CYCLES cycles after SHOWn entry.
- `foul` is high for exactly the one cycle after the offending edge.
- With `req` held high continuously, only one request is generated. A new request requires a release and then a press.

## Test plan
- Normal round: with defaults, `start`; `req1` edge -> `roll_go` one cycle later, `turn`=1. `roll_done` with `sum`=7 -> `last_sum`=7, WAIT2 after 4 cycles with `turn`=2. `req2` and `roll_done` with `sum`=9, `game_over`=0 -> `round_cnt`=1, `turn`=1.
- Game over: in SHOW1 with `sum`=11 and `game_over`=1 -> DONE, `turn`=0, `busy`=0, `draw`=0. `start` -> `round_cnt`=0, WAIT1.
- Fouls: in WAIT1 pulse `req2` -> `foul` one cycle, state unchanged. Simultaneous `req1`/`req2` edges -> ROLL1 and one `foul` pulse. Holding `req1` high for 20 cycles -> exactly one `roll_go`.
- Timeout: with ROLL_TIMEOUT=8, issue no `roll_done` -> FAULT 8 cycles after ROLL1 entry, `fault`=1. `roll_done` arriving on the final cycle instead -> SHOW1, no fault.
- Draw: with MAX_ROUNDS=2 and `game_over` held 0, play 2 full rounds -> DONE, `draw`=1, `round_cnt`=2.
- Reset mid-operation: assert `rst`=0 during ROLL2 -> next cycle all outputs 0, IDLE. A later `roll_done` and `req1` are ignored until `start`.
